// File: rtl/laser_cover_scorer.sv
// laser_cover_scorer
//   Downstream checker for the LASER dual-circle placement block. It captures
//   the same NUM_PT-target frame that is streamed into LASER. When LASER
//   pulses DONE, it samples both circle centres and walks the stored frame
//   once. For each circle it counts the targets inside the radius, the
//   targets inside both circles, and the targets inside at least one.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   PT_VALID, X, Y      frame target stream (one target per valid cycle)
//   DONE                LASER result pulse; C1X..C2Y valid while high
//   C1X, C1Y, C2X, C2Y  LASER circle centres
//   SCORE               targets covered by C1 or C2
//   C1_CNT, C2_CNT      targets covered by C1 / by C2
//   BOTH_CNT            targets covered by both circles
//   SCORE_VALID         one-cycle pulse, results valid
//   ERR                 one-cycle pulse, DONE arrived before a full frame
//   BUSY                high while waiting for DONE or evaluating
module laser_cover_scorer #(
  parameter int NUM_PT    = 40,
  parameter int RADIUS_SQ = 16,
  parameter int CW        = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PT_VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          DONE,
  input  logic [CW-1:0] C1X,
  input  logic [CW-1:0] C1Y,
  input  logic [CW-1:0] C2X,
  input  logic [CW-1:0] C2Y,
  output logic [5:0]    SCORE,
  output logic [5:0]    C1_CNT,
  output logic [5:0]    C2_CNT,
  output logic [5:0]    BOTH_CNT,
  output logic          SCORE_VALID,
  output logic          ERR,
  output logic          BUSY
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [5:0] LAST_IDX = 6'(NUM_PT - 1);

  // Absolute difference without wrap-around: |15 - 0| is 15, not 1.
  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic covered(input logic [CW-1:0] px,
                                   input logic [CW-1:0] py,
                                   input logic [CW-1:0] cx,
                                   input logic [CW-1:0] cy);
    logic [CW-1:0]   dx;
    logic [CW-1:0]   dy;
    logic [2*CW-1:0] sx;
    logic [2*CW-1:0] sy;
    logic [2*CW:0]   sum;
    dx  = abs_diff(px, cx);
    dy  = abs_diff(py, cy);
    sx  = (2*CW)'(dx) * (2*CW)'(dx);
    sy  = (2*CW)'(dy) * (2*CW)'(dy);
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= (2*CW+1)'(RADIUS_SQ);
  endfunction

  logic [1:0]      state_q,    state_d;
  logic [5:0]      ptr_q,      ptr_d;
  logic [5:0]      idx_q,      idx_d;
  logic [5:0]      acc_s_q,    acc_s_d;
  logic [5:0]      acc_c1_q,   acc_c1_d;
  logic [5:0]      acc_c2_q,   acc_c2_d;
  logic [5:0]      acc_b_q,    acc_b_d;
  logic [5:0]      score_q,    score_d;
  logic [5:0]      c1_cnt_q,   c1_cnt_d;
  logic [5:0]      c2_cnt_q,   c2_cnt_d;
  logic [5:0]      both_cnt_q, both_cnt_d;
  logic            sv_q,       sv_d;
  logic            err_q,      err_d;
  logic [CW-1:0]   c1x_q, c1y_q, c2x_q, c2y_q;
  logic [CW-1:0]   c1x_d, c1y_d, c2x_d, c2y_d;

  // Frame buffer, packed {x, y}. Never read before being rewritten, so it
  // carries no reset.
  logic [2*CW-1:0] buf_q [NUM_PT];
  logic            buf_we;
  logic [2*CW-1:0] buf_wdata;

  logic [2*CW-1:0] entry;
  logic            in1;
  logic            in2;

  assign entry = buf_q[idx_q];
  assign in1   = covered(entry[2*CW-1:CW], entry[CW-1:0], c1x_q, c1y_q);
  assign in2   = covered(entry[2*CW-1:CW], entry[CW-1:0], c2x_q, c2y_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    acc_s_d    = acc_s_q;
    acc_c1_d   = acc_c1_q;
    acc_c2_d   = acc_c2_q;
    acc_b_d    = acc_b_q;
    score_d    = score_q;
    c1_cnt_d   = c1_cnt_q;
    c2_cnt_d   = c2_cnt_q;
    both_cnt_d = both_cnt_q;
    sv_d       = 1'b0;
    err_d      = 1'b0;
    c1x_d      = c1x_q;
    c1y_d      = c1y_q;
    c2x_d      = c2x_q;
    c2y_d      = c2y_q;
    buf_we     = 1'b0;
    buf_wdata  = {X, Y};

    case (state_q)
      S_LOAD: begin
        // DONE wins over a simultaneous final store: the frame is short.
        if (DONE) begin
          err_d      = 1'b1;
          score_d    = '0;
          c1_cnt_d   = '0;
          c2_cnt_d   = '0;
          both_cnt_d = '0;
          ptr_d      = '0;
        end else if (PT_VALID) begin
          buf_we = 1'b1;
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            state_d = S_WAIT;
          end else begin
            ptr_d = ptr_q + 6'd1;
          end
        end
      end
      S_WAIT: begin
        if (DONE) begin
          c1x_d    = C1X;
          c1y_d    = C1Y;
          c2x_d    = C2X;
          c2y_d    = C2Y;
          acc_s_d  = '0;
          acc_c1_d = '0;
          acc_c2_d = '0;
          acc_b_d  = '0;
          idx_d    = '0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        acc_c1_d = acc_c1_q + 6'(in1);
        acc_c2_d = acc_c2_q + 6'(in2);
        acc_b_d  = acc_b_q  + 6'(in1 & in2);
        acc_s_d  = acc_s_q  + 6'(in1 | in2);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_REPORT;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: begin
        score_d    = acc_s_q;
        c1_cnt_d   = acc_c1_q;
        c2_cnt_d   = acc_c2_q;
        both_cnt_d = acc_b_q;
        sv_d       = 1'b1;
        ptr_d      = '0;
        state_d    = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_LOAD;
      ptr_q      <= '0;
      idx_q      <= '0;
      acc_s_q    <= '0;
      acc_c1_q   <= '0;
      acc_c2_q   <= '0;
      acc_b_q    <= '0;
      score_q    <= '0;
      c1_cnt_q   <= '0;
      c2_cnt_q   <= '0;
      both_cnt_q <= '0;
      sv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      acc_s_q    <= acc_s_d;
      acc_c1_q   <= acc_c1_d;
      acc_c2_q   <= acc_c2_d;
      acc_b_q    <= acc_b_d;
      score_q    <= score_d;
      c1_cnt_q   <= c1_cnt_d;
      c2_cnt_q   <= c2_cnt_d;
      both_cnt_q <= both_cnt_d;
      sv_q       <= sv_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    c1x_q <= c1x_d;
    c1y_q <= c1y_d;
    c2x_q <= c2x_d;
    c2y_q <= c2y_d;
    if (buf_we) begin
      buf_q[ptr_q] <= buf_wdata;
    end
  end

  assign SCORE       = score_q;
  assign C1_CNT      = c1_cnt_q;
  assign C2_CNT      = c2_cnt_q;
  assign BOTH_CNT    = both_cnt_q;
  assign SCORE_VALID = sv_q;
  assign ERR         = err_q;
  assign BUSY        = (state_q == S_WAIT) || (state_q == S_EVAL);

endmodule

// File: tb/tb_laser_cover_scorer.sv
// tb_laser_cover_scorer
//   Self-checking bench for laser_cover_scorer: a table of directed frames
//   with hand-computed scores, corner-case sequences (short frames, reset
//   mid-evaluation), and randomized back-to-back frames checked against a
//   distance-based reference model.
module tb_laser_cover_scorer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PT_VALID;
  logic [3:0] X, Y;
  logic       DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic [5:0] SCORE, C1_CNT, C2_CNT, BOTH_CNT;
  logic       SCORE_VALID, ERR, BUSY;

  laser_cover_scorer dut (
    .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .SCORE(SCORE), .C1_CNT(C1_CNT), .C2_CNT(C2_CNT), .BOTH_CNT(BOTH_CNT),
    .SCORE_VALID(SCORE_VALID), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] fx [40];
  logic [3:0] fy [40];

  typedef struct {
    logic [3:0] ax, ay, bx, by;     // first 20 targets at a, last 20 at b
    logic [3:0] c1x, c1y, c2x, c2y;
    int         s, c1, c2, both;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: coverage straight from Euclidean distance on integers.
  function automatic void model(input logic [3:0] ax, input logic [3:0] ay,
                                input logic [3:0] bx, input logic [3:0] by,
                                output int s, output int c1, output int c2,
                                output int both);
    s = 0; c1 = 0; c2 = 0; both = 0;
    for (int i = 0; i < 40; i++) begin
      int  d1x, d1y, d2x, d2y;
      bit  in1, in2;
      d1x = int'(fx[i]) - int'(ax);
      d1y = int'(fy[i]) - int'(ay);
      d2x = int'(fx[i]) - int'(bx);
      d2y = int'(fy[i]) - int'(by);
      in1 = (d1x * d1x + d1y * d1y) <= 16;
      in2 = (d2x * d2x + d2y * d2y) <= 16;
      c1   += int'(in1);
      c2   += int'(in2);
      both += int'(in1 && in2);
      s    += int'(in1 || in2);
    end
  endfunction

  task automatic fill_vec(input int v);
    for (int i = 0; i < 40; i++) begin
      fx[i] = (i < 20) ? vecs[v].ax : vecs[v].bx;
      fy[i] = (i < 20) ? vecs[v].ay : vecs[v].by;
    end
  endtask

  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      PT_VALID = 1'b1;
      X = fx[i];
      Y = fy[i];
      step();
    end
    PT_VALID = 1'b0;
  endtask

  // Called with the frame fully loaded. Pulses DONE, then waits (bounded)
  // for SCORE_VALID and checks latency and all counts. Returns in the cycle
  // where SCORE_VALID is high so the next frame can stream immediately.
  task automatic done_and_wait(input string tag,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d,
                               input int es, input int ec1, input int ec2,
                               input int eb, input bit noise);
    int cycles;
    bit got;
    check({tag, "_busy_wait"}, int'(BUSY), 1);
    if (noise) begin
      repeat (3) begin
        PT_VALID = 1'b1;
        X = 4'($urandom);
        Y = 4'($urandom);
        step();
      end
      PT_VALID = 1'b0;
    end
    C1X = a; C1Y = b; C2X = c; C2Y = d;
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    // Centres are only valid with DONE; scramble them afterwards.
    C1X = 4'($urandom); C1Y = 4'($urandom);
    C2X = 4'($urandom); C2Y = 4'($urandom);
    cycles = 0;
    got    = 1'b0;
    while (cycles < 60 && !got) begin
      if (noise) begin
        PT_VALID = 1'($urandom);
        X = 4'($urandom);
        Y = 4'($urandom);
        DONE = (cycles < 35) && ($urandom_range(0, 3) == 0);
      end
      step();
      cycles++;
      if (SCORE_VALID) got = 1'b1;
    end
    PT_VALID = 1'b0;
    DONE     = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no SCORE_VALID in %0d cycles expected one at 41",
               tag, cycles);
    end else begin
      check({tag, "_latency"}, cycles, 41);
      check({tag, "_score"}, int'(SCORE), es);
      check({tag, "_c1"}, int'(C1_CNT), ec1);
      check({tag, "_c2"}, int'(C2_CNT), ec2);
      check({tag, "_both"}, int'(BOTH_CNT), eb);
      check({tag, "_invariant"}, int'(SCORE),
            int'(C1_CNT) + int'(C2_CNT) - int'(BOTH_CNT));
      check({tag, "_busy_done"}, int'(BUSY), 0);
    end
  endtask

  initial begin
    int s, c1, c2, b;
    logic [3:0] ra, rb, rc, rd;

    vecs[0] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0, 40, 40, 0, 0};
    vecs[1] = '{4'd12, 4'd8, 4'd12, 4'd9, 4'd8, 4'd8, 4'd8, 4'd8, 20, 20, 20, 20};
    vecs[2] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd11, 4'd11, 0, 0, 0, 0};
    vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd12, 4'd15, 40, 0, 40, 0};
    vecs[4] = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 40, 40, 40, 40};
    vecs[5] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd2, 4'd2, 4'd13, 4'd14, 40, 20, 20, 0};

    RST = 1'b1; PT_VALID = 1'b0; DONE = 1'b0;
    X = '0; Y = '0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (2) step();
    check("rst_score", int'(SCORE), 0);
    check("rst_c1", int'(C1_CNT), 0);
    check("rst_c2", int'(C2_CNT), 0);
    check("rst_both", int'(BOTH_CNT), 0);
    check("rst_sv", int'(SCORE_VALID), 0);
    check("rst_err", int'(ERR), 0);
    check("rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    step();

    // Directed table
    for (int v = 0; v < 6; v++) begin
      fill_vec(v);
      load_frame(40);
      done_and_wait($sformatf("vec%0d", v), vecs[v].c1x, vecs[v].c1y,
                    vecs[v].c2x, vecs[v].c2y, vecs[v].s, vecs[v].c1,
                    vecs[v].c2, vecs[v].both, 1'b0);
      step();
      check($sformatf("vec%0d_sv_pulse", v), int'(SCORE_VALID), 0);
      check($sformatf("vec%0d_hold", v), int'(SCORE), vecs[v].s);
    end

    // Short frame: 20 targets then DONE
    fill_vec(1);
    load_frame(20);
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("short_err", int'(ERR), 1);
    check("short_sv", int'(SCORE_VALID), 0);
    check("short_score", int'(SCORE), 0);
    check("short_c1", int'(C1_CNT), 0);
    check("short_busy", int'(BUSY), 0);
    step();
    check("short_err_pulse", int'(ERR), 0);
    fill_vec(0);
    load_frame(40);
    done_and_wait("after_short", 4'd8, 4'd8, 4'd0, 4'd0, 40, 40, 0, 0, 1'b0);
    step();

    // DONE on the same edge as the 40th store is still a short frame
    fill_vec(1);
    load_frame(39);
    PT_VALID = 1'b1; X = fx[39]; Y = fy[39]; DONE = 1'b1;
    step();
    PT_VALID = 1'b0; DONE = 1'b0;
    check("edge_short_err", int'(ERR), 1);
    check("edge_short_busy", int'(BUSY), 0);
    check("edge_short_score", int'(SCORE), 0);
    step();
    load_frame(40);
    done_and_wait("after_edge_short", 4'd8, 4'd8, 4'd8, 4'd8, 20, 20, 20, 20, 1'b0);
    step();

    // Reset mid-EVAL
    fill_vec(0);
    load_frame(40);
    C1X = 4'd8; C1Y = 4'd8; C2X = 4'd0; C2Y = 4'd0;
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    repeat (10) step();
    check("midrst_busy_before", int'(BUSY), 1);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_score", int'(SCORE), 0);
    check("midrst_c1", int'(C1_CNT), 0);
    check("midrst_c2", int'(C2_CNT), 0);
    check("midrst_both", int'(BOTH_CNT), 0);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_sv", int'(SCORE_VALID), 0);
    step();
    RST = 1'b0;
    step();
    fill_vec(5);
    load_frame(40);
    done_and_wait("after_rst", 4'd2, 4'd2, 4'd13, 4'd14, 40, 20, 20, 0, 1'b0);

    // Randomized back-to-back frames with noise on ignored inputs
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 40; i++) begin
        fx[i] = 4'($urandom);
        fy[i] = 4'($urandom);
      end
      ra = 4'($urandom); rb = 4'($urandom);
      if (f[0]) begin
        rc = ra; rd = rb;
      end else begin
        rc = 4'($urandom); rd = 4'($urandom);
      end
      model(ra, rb, rc, rd, s, c1, c2, b);
      load_frame(40);
      done_and_wait($sformatf("rand%0d", f), ra, rb, rc, rd, s, c1, c2, b, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected end of test");
    $fatal(1, "global timeout");
  end

endmodule
